// File: rtl/mem_pair_sched_pkg.sv
// Shared types and encodings for the dual-slot memory scheduler.
package mem_pair_sched_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_REQ1  = 3'd1;
  localparam state_t S_WAIT1 = 3'd2;
  localparam state_t S_REQ2  = 3'd3;
  localparam state_t S_WAIT2 = 3'd4;
  localparam state_t S_DRAIN = 3'd5;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/mem_pair_sched_slot.sv
// Holds one slot's request fields from launch until the request is issued.
module mem_slot_latch #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load,
  input  logic              wen,
  input  logic [1:0]        size,
  input  logic [3:0]        wstrb,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              wen_q,
  output logic [1:0]        size_q,
  output logic [3:0]        wstrb_q,
  output logic [DATA_W-1:0] addr_q,
  output logic [DATA_W-1:0] wdata_q
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wen_q   <= 1'b0;
      size_q  <= 2'd0;
      wstrb_q <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (load) begin
      wen_q   <= wen;
      size_q  <= size;
      wstrb_q <= wstrb;
      addr_q  <= addr;
      wdata_q <= wdata;
    end
  end

endmodule

// File: rtl/mem_pair_sched.sv
// Issues the two E-stage memory slots in order over one req/addr_ok/data_ok port.
module mem_pair_sched
  import mem_pair_sched_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              E_valid,
  input  logic              E_mem_en1,
  input  logic              E_mem_en2,
  input  logic              E_mem_wen1,
  input  logic              E_mem_wen2,
  input  logic [1:0]        E_mem_size1,
  input  logic [1:0]        E_mem_size2,
  input  logic [3:0]        E_mem_wstrb1,
  input  logic [3:0]        E_mem_wstrb2,
  input  logic [DATA_W-1:0] E_mem_addr1,
  input  logic [DATA_W-1:0] E_mem_addr2,
  input  logic [DATA_W-1:0] E_mem_wdata1,
  input  logic [DATA_W-1:0] E_mem_wdata2,
  input  logic              E_exp1,
  input  logic              E_exp2,
  input  logic              M_flush,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [1:0]        mem_size,
  output logic [3:0]        mem_wstrb,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              E_stall,
  output logic              M_done,
  output logic [DATA_W-1:0] M_rdata1,
  output logic [DATA_W-1:0] M_rdata2
);

  state_t state_q, state_d;
  logic sel1, sel2, start;
  logic sel2_q;
  logic done_d;
  logic [DATA_W-1:0] rdata1_d, rdata2_d;

  logic              s1_wen, s2_wen;
  logic [1:0]        s1_size, s2_size;
  logic [3:0]        s1_wstrb, s2_wstrb;
  logic [DATA_W-1:0] s1_addr, s2_addr, s1_wdata, s2_wdata;

  // An exception in slot 1 also kills slot 2, which is younger.
  assign sel1  = E_mem_en1 & ~E_exp1 & ~M_flush;
  assign sel2  = E_mem_en2 & ~E_exp1 & ~E_exp2 & ~M_flush;
  assign start = (state_q == S_IDLE) & E_valid & ~M_done & (sel1 | sel2);

  assign E_stall = start | (state_q != S_IDLE);

  mem_slot_latch #(.DATA_W(DATA_W)) u_slot1 (
    .clk     (clk),
    .resetn  (resetn),
    .load    (start),
    .wen     (E_mem_wen1),
    .size    (E_mem_size1),
    .wstrb   (E_mem_wstrb1),
    .addr    (E_mem_addr1),
    .wdata   (E_mem_wdata1),
    .wen_q   (s1_wen),
    .size_q  (s1_size),
    .wstrb_q (s1_wstrb),
    .addr_q  (s1_addr),
    .wdata_q (s1_wdata)
  );

  mem_slot_latch #(.DATA_W(DATA_W)) u_slot2 (
    .clk     (clk),
    .resetn  (resetn),
    .load    (start),
    .wen     (E_mem_wen2),
    .size    (E_mem_size2),
    .wstrb   (E_mem_wstrb2),
    .addr    (E_mem_addr2),
    .wdata   (E_mem_wdata2),
    .wen_q   (s2_wen),
    .size_q  (s2_size),
    .wstrb_q (s2_wstrb),
    .addr_q  (s2_addr),
    .wdata_q (s2_wdata)
  );

  always_comb begin
    mem_req   = 1'b0;
    mem_wr    = 1'b0;
    mem_size  = 2'd0;
    mem_wstrb = 4'd0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q == S_REQ1) begin
      mem_req   = ~M_flush;
      mem_wr    = s1_wen;
      mem_size  = s1_size;
      mem_wstrb = s1_wstrb;
      mem_addr  = s1_addr;
      mem_wdata = s1_wdata;
    end else if (state_q == S_REQ2) begin
      mem_req   = ~M_flush;
      mem_wr    = s2_wen;
      mem_size  = s2_size;
      mem_wstrb = s2_wstrb;
      mem_addr  = s2_addr;
      mem_wdata = s2_wdata;
    end
  end

  always_comb begin
    state_d  = state_q;
    done_d   = 1'b0;
    rdata1_d = M_rdata1;
    rdata2_d = M_rdata2;
    case (state_q)
      S_IDLE: if (start) state_d = sel1 ? S_REQ1 : S_REQ2;
      S_REQ1: begin
        if (M_flush)          state_d = S_IDLE;
        else if (mem_addr_ok) state_d = S_WAIT1;
      end
      S_WAIT1: begin
        // A response arriving with the flush has nothing left to drain.
        if (M_flush) begin
          state_d = mem_data_ok ? S_IDLE : S_DRAIN;
        end else if (mem_data_ok) begin
          if (!s1_wen) rdata1_d = mem_rdata;
          if (sel2_q) begin
            state_d = S_REQ2;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      S_REQ2: begin
        if (M_flush)          state_d = S_IDLE;
        else if (mem_addr_ok) state_d = S_WAIT2;
      end
      S_WAIT2: begin
        if (M_flush) begin
          state_d = mem_data_ok ? S_IDLE : S_DRAIN;
        end else if (mem_data_ok) begin
          if (!s2_wen) rdata2_d = mem_rdata;
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      S_DRAIN: if (mem_data_ok) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      sel2_q   <= 1'b0;
      M_done   <= 1'b0;
      M_rdata1 <= '0;
      M_rdata2 <= '0;
    end else begin
      state_q  <= state_d;
      M_done   <= done_d;
      M_rdata1 <= rdata1_d;
      M_rdata2 <= rdata2_d;
      if (start) sel2_q <= sel2;
    end
  end

endmodule
